// File: rtl/multi_stream_buffer_if.sv
// AXI3 read-only channel bundle (AR + R) between a read master and its interconnect.
interface axi3_rd_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/multi_stream_buffer.sv
// Small fully-associative line buffer: fetches whole lines over AXI3 read bursts,
// serves combinational lookups and hands used lines back to the cache arrays.
module multi_stream_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ENTRY_NUM  = 4,
  parameter int ARID       = 0,
  localparam int WORDS     = LINE_WIDTH / DATA_WIDTH,
  localparam int OFS       = $clog2(LINE_WIDTH / 8),
  localparam int LABEL_W   = 32 - OFS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LABEL_W-1:0]    req_label,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  inv,
  input  logic [LABEL_W-1:0]    lkup_label,
  output logic                  lkup_hit,
  output logic [LINE_WIDTH-1:0] lkup_line,
  output logic [WORDS-1:0]      lkup_word_vld,
  input  logic                  lkup_use,
  output logic                  out_valid,
  output logic [LABEL_W-1:0]    out_label,
  output logic [LINE_WIDTH-1:0] out_line,
  input  logic                  out_ready,
  axi3_rd_if.master             axi
);
  localparam int IDX_W  = $clog2(ENTRY_NUM);
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SIZE   = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

  state_t                state_r, state_s;
  logic [ENTRY_NUM-1:0]  valid_r, was_hit_r, written_r;
  logic [LABEL_W-1:0]    label_r [ENTRY_NUM];
  logic [LINE_WIDTH-1:0] line_r [ENTRY_NUM];
  logic [WORDS-1:0]      word_vld_r [ENTRY_NUM];
  logic [IDX_W-1:0]      rr_ptr_r, fill_idx_r;
  logic [BEAT_W-1:0]     beat_r;
  logic                  discard_r;

  logic [ENTRY_NUM-1:0]  lkup_vec_s, req_vec_s, elig_vec_s;
  logic [IDX_W-1:0]      lkup_idx_s, out_idx_s, victim_s;
  logic                  use_ptr_s, req_fire_s, alloc_s, beat_fire_s, unused_s;

  function automatic logic [IDX_W-1:0] low_idx(input logic [ENTRY_NUM-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // Per-entry match and write-back eligibility vectors.
  always_comb begin
    lkup_vec_s = '0;
    req_vec_s  = '0;
    elig_vec_s = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      lkup_vec_s[i] = valid_r[i] && (label_r[i] == lkup_label);
      req_vec_s[i]  = valid_r[i] && (label_r[i] == req_label);
      elig_vec_s[i] = valid_r[i] && (&word_vld_r[i]) && was_hit_r[i] && !written_r[i];
    end
  end

  assign lkup_idx_s    = low_idx(lkup_vec_s);
  assign out_idx_s     = low_idx(elig_vec_s);
  assign lkup_hit      = (|lkup_vec_s) & ~rst;
  assign lkup_line     = lkup_hit ? line_r[lkup_idx_s] : {LINE_WIDTH{1'b0}};
  assign lkup_word_vld = lkup_hit ? word_vld_r[lkup_idx_s] : {WORDS{1'b0}};
  assign out_valid     = (|elig_vec_s) & ~rst;
  assign out_label     = out_valid ? label_r[out_idx_s] : {LABEL_W{1'b0}};
  assign out_line      = out_valid ? line_r[out_idx_s] : {LINE_WIDTH{1'b0}};

  // Requests are only taken in IDLE, so no entry is mid-fill when a victim is picked.
  assign use_ptr_s   = &valid_r;
  assign victim_s    = use_ptr_s ? rr_ptr_r : low_idx(~valid_r);
  assign req_ready   = (state_r == IDLE) & ~inv;
  assign req_fire_s  = req_valid & req_ready;
  assign alloc_s     = req_fire_s & ~(|req_vec_s);
  assign beat_fire_s = (state_r == R) & axi.rvalid;

  assign axi.arvalid = (state_r == AR) & ~rst;
  assign axi.araddr  = {label_r[fill_idx_r], {OFS{1'b0}}};
  assign axi.arlen   = 4'(WORDS - 1);
  assign axi.arsize  = 3'(SIZE);
  assign axi.arburst = 2'b01;
  assign axi.arid    = ARID[3:0];
  assign axi.rready  = (state_r == R) & ~rst;
  assign unused_s    = ^axi.rid;

  // Fill FSM next state: one burst at a time.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (alloc_s) state_s = AR; else state_s = IDLE;
      AR:   if (axi.arready) state_s = R; else state_s = AR;
      R:    if (axi.rvalid && axi.rlast) state_s = IDLE; else state_s = R;
      default: state_s = IDLE;
    endcase
  end

  // Entry state, fill bookkeeping and the invalidate override.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      was_hit_r  <= '0;
      written_r  <= '0;
      rr_ptr_r   <= '0;
      fill_idx_r <= '0;
      beat_r     <= '0;
      discard_r  <= 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) word_vld_r[i] <= '0;
    end else begin
      state_r <= state_s;
      if (alloc_s) begin
        label_r[victim_s]    <= req_label;
        valid_r[victim_s]    <= 1'b1;
        word_vld_r[victim_s] <= '0;
        was_hit_r[victim_s]  <= 1'b0;
        written_r[victim_s]  <= 1'b0;
        fill_idx_r           <= victim_s;
        beat_r               <= '0;
        if (use_ptr_s) rr_ptr_r <= rr_ptr_r + IDX_W'(1);
      end
      // A line being (re)allocated this cycle must not inherit stale use/write marks.
      if (lkup_use && lkup_hit && !inv && !(alloc_s && victim_s == lkup_idx_s))
        was_hit_r[lkup_idx_s] <= 1'b1;
      if (out_valid && out_ready && !inv && !(alloc_s && victim_s == out_idx_s))
        written_r[out_idx_s] <= 1'b1;
      if (beat_fire_s) begin
        beat_r <= beat_r + BEAT_W'(1);
        if (!discard_r && !inv) begin
          line_r[fill_idx_r][int'(beat_r) * DATA_WIDTH +: DATA_WIDTH] <= axi.rdata;
          word_vld_r[fill_idx_r][beat_r] <= 1'b1;
        end
        if (axi.rlast) discard_r <= 1'b0;
      end
      if (inv) begin
        valid_r <= '0;
        if (state_r != IDLE) discard_r <= ~(beat_fire_s & axi.rlast);
      end
    end
  end
endmodule
